// File: rtl/ex_pkg.sv
// Shared encodings for the EX stage: mul/div opcodes, forward selects,
// MD sequencer states and ALU opcodes.
package ex_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_ZERO  = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

endpackage

// File: rtl/mdu_iter.sv
// Radix-2 iterative multiply/divide: shift-add multiply and restoring divide
// on operand magnitudes, with sign fix-up applied to the final result.
module mdu_iter
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic            hold,
  input  md_op_e          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  md_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] hi_q, lo_q, bmag_q, spec_q;
  logic            special_q, neg_q, neg_r_q;
  md_op_e          op_q;

  logic            a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, spec_val;

  always_comb begin
    a_signed = (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    b_signed = (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    a_neg    = a_signed & a[XLEN-1];
    b_neg    = b_signed & b[XLEN-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    div_zero = op[2] && (b == '0);
    div_ovf  = ((op == MD_DIV) || (op == MD_REM)) &&
               (a == {1'b1, {(XLEN-1){1'b0}}}) && (&b);
    // op[1] separates REM/REMU from DIV/DIVU
    if (div_zero) spec_val = op[1] ? a : '1;
    else          spec_val = op[1] ? '0 : a;
  end

  logic [XLEN:0]   mul_sum;
  logic [2*XLEN:0] mul_shift;
  logic [XLEN:0]   div_shift;
  logic [XLEN+1:0] div_diff;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, bmag_q} : '0);
    mul_shift = {mul_sum, lo_q} >> 1;
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = {1'b0, div_shift} - {2'b0, bmag_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MD_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = MD_IDLE;
    end else begin
      case (state_q)
        MD_IDLE: if (start) state_d = MD_BUSY;
        MD_BUSY: if (cnt_q == '0) state_d = MD_DONE;
        MD_DONE: if (!hold) state_d = MD_IDLE;
        default: state_d = MD_IDLE;
      endcase
    end
  end

  // Divide-by-zero and signed overflow start with the counter at zero so
  // they leave BUSY after a single cycle; the iteration result is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      bmag_q    <= '0;
      spec_q    <= '0;
      special_q <= 1'b0;
      neg_q     <= 1'b0;
      neg_r_q   <= 1'b0;
      op_q      <= MD_MUL;
    end else if (flush) begin
      cnt_q <= '0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start) begin
            op_q      <= op;
            hi_q      <= '0;
            lo_q      <= a_mag;
            bmag_q    <= b_mag;
            neg_q     <= a_neg ^ b_neg;
            neg_r_q   <= a_neg;
            special_q <= div_zero | div_ovf;
            spec_q    <= spec_val;
            cnt_q     <= (div_zero | div_ovf) ? '0 : CW'(XLEN-1);
          end
        end
        MD_BUSY: begin
          if (op_q[2]) begin
            if (!div_diff[XLEN+1]) begin
              hi_q <= div_diff[XLEN-1:0];
              lo_q <= {lo_q[XLEN-2:0], 1'b1};
            end else begin
              hi_q <= div_shift[XLEN-1:0];
              lo_q <= {lo_q[XLEN-2:0], 1'b0};
            end
          end else begin
            {hi_q, lo_q} <= mul_shift[2*XLEN-1:0];
          end
          if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;

  always_comb begin
    prod = {hi_q, lo_q};
    if (neg_q) prod = -prod;
    quo = neg_q   ? -lo_q : lo_q;
    rem = neg_r_q ? -hi_q : hi_q;
    if (special_q) begin
      result = spec_q;
    end else begin
      case (op_q)
        MD_MUL:                       result = prod[XLEN-1:0];
        MD_MULH, MD_MULHSU, MD_MULHU: result = prod[2*XLEN-1:XLEN];
        MD_DIV, MD_DIVU:              result = quo;
        default:                      result = rem;
      endcase
    end
  end

  assign busy = (state_q == MD_BUSY);
  assign done = (state_q == MD_DONE);

endmodule

// File: rtl/ex_stage_mdu.sv
// Execute stage: operand forwarding, single-cycle ALU, and an optional
// iterative mul/div unit sharing the registered EX/MEM outputs.
module ex_stage_mdu
  import ex_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit MD_ENABLE = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic            alusrc_b_i,
  input  logic            auipc_i,
  input  logic [3:0]      alu_ctrl_i,
  input  logic            md_en_i,
  input  logic [2:0]      md_op_i,
  input  logic [XLEN-1:0] fwd_exmem_i,
  input  logic [XLEN-1:0] fwd_memwb_i,
  input  logic [1:0]      a_fwd_i,
  input  logic [1:0]      b_fwd_i,
  input  logic            mem_stall_i,
  output logic            ready_o,
  output logic            valid_o,
  output logic [XLEN-1:0] alu_out_o,
  output logic            zero_o,
  output logic [XLEN-1:0] rs2_out_o,
  output logic [XLEN-1:0] pc_target_o,
  output logic [XLEN-1:0] pc4_o
);

  localparam int SHW = $clog2(XLEN);

  function automatic logic [XLEN-1:0] fwd_sel(input logic [1:0] sel,
                                              input logic [XLEN-1:0] base,
                                              input logic [XLEN-1:0] exmem,
                                              input logic [XLEN-1:0] memwb);
    case (sel)
      FWD_EXMEM: return exmem;
      FWD_MEMWB: return memwb;
      FWD_ZERO:  return '0;
      default:   return base;
    endcase
  endfunction

  logic [XLEN-1:0] a_op, rs2_fwd, b_op, alu_res;
  logic [SHW-1:0]  shamt;

  always_comb begin
    a_op    = fwd_sel(a_fwd_i, auipc_i ? pc_i : rs1_i, fwd_exmem_i, fwd_memwb_i);
    rs2_fwd = fwd_sel(b_fwd_i, rs2_i, fwd_exmem_i, fwd_memwb_i);
    b_op    = alusrc_b_i ? imm_i : rs2_fwd;
    shamt   = b_op[SHW-1:0];
    alu_res = '0;
    case (alu_ctrl_i)
      ALU_ADD:   alu_res = a_op + b_op;
      ALU_SUB:   alu_res = a_op - b_op;
      ALU_AND:   alu_res = a_op & b_op;
      ALU_OR:    alu_res = a_op | b_op;
      ALU_XOR:   alu_res = a_op ^ b_op;
      ALU_SLL:   alu_res = a_op << shamt;
      ALU_SRL:   alu_res = a_op >> shamt;
      ALU_SRA:   alu_res = XLEN'($signed(a_op) >>> shamt);
      ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(a_op) < $signed(b_op)};
      ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, a_op < b_op};
      ALU_PASSB: alu_res = b_op;
      default:   alu_res = '0;
    endcase
  end

  logic            md_busy, md_done, md_en_eff, accept, md_start, alu_accept;
  logic [XLEN-1:0] md_result;

  assign md_en_eff  = MD_ENABLE && md_en_i;
  assign ready_o    = !(md_busy || md_done);
  assign accept     = valid_i && ready_o && !mem_stall_i && !flush_i;
  assign md_start   = accept && md_en_eff;
  assign alu_accept = accept && !md_en_eff;

  generate
    if (MD_ENABLE) begin : g_mdu
      mdu_iter #(.XLEN(XLEN)) u_mdu (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .flush  (flush_i),
        .hold   (mem_stall_i),
        .op     (md_op_e'(md_op_i)),
        .a      (a_op),
        .b      (rs2_fwd),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
      );
    end else begin : g_no_mdu
      assign md_busy   = 1'b0;
      assign md_done   = 1'b0;
      assign md_result = '0;
    end
  endgenerate

  // Side-band values of an MD instruction are captured at acceptance and
  // released together with the result.
  logic [XLEN-1:0] md_rs2_q, md_pct_q, md_pc4_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_rs2_q <= '0;
      md_pct_q <= '0;
      md_pc4_q <= '0;
    end else if (md_start) begin
      md_rs2_q <= rs2_fwd;
      md_pct_q <= pc_i + imm_i;
      md_pc4_q <= pc_i + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o     <= 1'b0;
      alu_out_o   <= '0;
      zero_o      <= 1'b0;
      rs2_out_o   <= '0;
      pc_target_o <= '0;
      pc4_o       <= '0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
    end else if (!mem_stall_i) begin
      if (md_done) begin
        valid_o     <= 1'b1;
        alu_out_o   <= md_result;
        zero_o      <= (md_result == '0);
        rs2_out_o   <= md_rs2_q;
        pc_target_o <= md_pct_q;
        pc4_o       <= md_pc4_q;
      end else if (alu_accept) begin
        valid_o     <= 1'b1;
        alu_out_o   <= alu_res;
        zero_o      <= (alu_res == '0);
        rs2_out_o   <= rs2_fwd;
        pc_target_o <= pc_i + imm_i;
        pc4_o       <= pc_i + XLEN'(4);
      end else begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_mdu.sv
// Directed bench for ex_stage_mdu (XLEN=32): ALU/forwarding, mul/div results
// and latency, stall hold, flush and reset abort.
module tb_ex_stage_mdu;
  import ex_pkg::*;

  logic        clk, rst_n;
  logic        valid_i, flush_i, alusrc_b_i, auipc_i, md_en_i, mem_stall_i;
  logic [31:0] pc_i, rs1_i, rs2_i, imm_i, fwd_exmem_i, fwd_memwb_i;
  logic [3:0]  alu_ctrl_i;
  logic [2:0]  md_op_i;
  logic [1:0]  a_fwd_i, b_fwd_i;
  logic        ready_o, valid_o, zero_o;
  logic [31:0] alu_out_o, rs2_out_o, pc_target_o, pc4_o;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  ex_stage_mdu #(.XLEN(32), .MD_ENABLE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .flush_i(flush_i),
    .pc_i(pc_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
    .alusrc_b_i(alusrc_b_i), .auipc_i(auipc_i), .alu_ctrl_i(alu_ctrl_i),
    .md_en_i(md_en_i), .md_op_i(md_op_i), .fwd_exmem_i(fwd_exmem_i),
    .fwd_memwb_i(fwd_memwb_i), .a_fwd_i(a_fwd_i), .b_fwd_i(b_fwd_i),
    .mem_stall_i(mem_stall_i), .ready_o(ready_o), .valid_o(valid_o),
    .alu_out_o(alu_out_o), .zero_o(zero_o), .rs2_out_o(rs2_out_o),
    .pc_target_o(pc_target_o), .pc4_o(pc4_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one ALU instruction for one accepting edge, then deasserts valid.
  task automatic applyStimulus(input logic [3:0] ctrl, input logic [31:0] r1, input logic [31:0] r2,
                               input logic [31:0] im, input logic bsel, input logic ap,
                               input logic [1:0] af, input logic [1:0] bf);
    @(negedge clk);
    valid_i = 1'b1; md_en_i = 1'b0; alu_ctrl_i = ctrl; rs1_i = r1; rs2_i = r2;
    imm_i = im; alusrc_b_i = bsel; auipc_i = ap; a_fwd_i = af; b_fwd_i = bf;
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic runMd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic z, output int low, output logic tmo);
    @(negedge clk);
    valid_i = 1'b1; md_en_i = 1'b1; md_op_i = op; rs1_i = a; rs2_i = b;
    a_fwd_i = FWD_REG; b_fwd_i = FWD_REG; alusrc_b_i = 1'b0; auipc_i = 1'b0;
    low = 0;
    tmo = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      valid_i = 1'b0; md_en_i = 1'b0;
      if (valid_o) begin
        tmo = 1'b0;
        break;
      end
      if (!ready_o) low++;
    end
    res = alu_out_o;
    z   = zero_o;
  endtask

  logic [31:0] res;
  logic        z, tmo;
  int          low, pulses, unstable;

  initial begin
    rst_n = 1'b0; valid_i = 0; flush_i = 0; alusrc_b_i = 0; auipc_i = 0; md_en_i = 0;
    mem_stall_i = 0; pc_i = 32'h100; rs1_i = 0; rs2_i = 0; imm_i = 0;
    fwd_exmem_i = 0; fwd_memwb_i = 0; alu_ctrl_i = ALU_ADD; md_op_i = MD_MUL;
    a_fwd_i = FWD_REG; b_fwd_i = FWD_REG;
    #1;
    checkOutput("rst_valid", 32'(valid_o), 32'd0);
    checkOutput("rst_alu", alu_out_o, 32'd0);
    checkOutput("rst_pc4", pc4_o, 32'd0);
    checkOutput("rst_ready", 32'(ready_o), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] ALU and forwarding");
    applyStimulus(ALU_ADD, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0, FWD_REG, FWD_REG);
    checkOutput("add_alu", alu_out_o, 32'd12);
    checkOutput("add_zero", 32'(zero_o), 32'd0);
    checkOutput("add_valid", 32'(valid_o), 32'd1);
    checkOutput("add_rs2", rs2_out_o, 32'd7);
    checkOutput("add_pc4", pc4_o, 32'h104);
    checkOutput("add_target", pc_target_o, 32'h100);
    @(negedge clk);
    checkOutput("idle_valid", 32'(valid_o), 32'd0);
    checkOutput("idle_hold", alu_out_o, 32'd12);

    fwd_exmem_i = 32'd100;
    applyStimulus(ALU_ADD, 32'd1, 32'd0, 32'd4, 1'b1, 1'b0, FWD_EXMEM, FWD_REG);
    checkOutput("fwd_exmem", alu_out_o, 32'd104);
    checkOutput("fwd_target", pc_target_o, 32'h104);
    applyStimulus(ALU_ADD, 32'd1, 32'd0, 32'd4, 1'b1, 1'b0, FWD_ZERO, FWD_REG);
    checkOutput("fwd_zero", alu_out_o, 32'd4);
    fwd_memwb_i = 32'd9;
    applyStimulus(ALU_SUB, 32'd9, 32'd3, 32'd0, 1'b0, 1'b0, FWD_REG, FWD_MEMWB);
    checkOutput("sub_alu", alu_out_o, 32'd0);
    checkOutput("sub_zero", 32'(zero_o), 32'd1);
    checkOutput("memwb_rs2", rs2_out_o, 32'd9);
    applyStimulus(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, FWD_REG, FWD_REG);
    checkOutput("slt", alu_out_o, 32'd1);
    applyStimulus(ALU_SRA, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 1'b0, FWD_REG, FWD_REG);
    checkOutput("sra", alu_out_o, 32'hF800_0000);
    applyStimulus(ALU_ADD, 32'd0, 32'd0, 32'h20, 1'b1, 1'b1, FWD_REG, FWD_REG);
    checkOutput("auipc", alu_out_o, 32'h120);

    valid_i = 1'b1; mem_stall_i = 1'b1; alu_ctrl_i = ALU_XOR; auipc_i = 1'b0;
    @(negedge clk);
    checkOutput("stall_valid", 32'(valid_o), 32'd1);
    checkOutput("stall_alu", alu_out_o, 32'h120);
    valid_i = 1'b0; mem_stall_i = 1'b0;
    @(negedge clk);

    $display("[TB] multiply/divide");
    pc_i = 32'h200;
    runMd(MD_MUL, 32'hFFFF_FFFF, 32'd2, res, z, low, tmo);
    checkOutput("mul_timeout", 32'(tmo), 32'd0);
    checkOutput("mul", res, 32'hFFFF_FFFE);
    checkOutput("mul_busy_cycles", 32'(low), 32'd33);
    checkOutput("mul_ready_after", 32'(ready_o), 32'd1);
    checkOutput("mul_rs2", rs2_out_o, 32'd2);
    checkOutput("mul_pc4", pc4_o, 32'h204);
    @(negedge clk);
    checkOutput("mul_single_pulse", 32'(valid_o), 32'd0);
    runMd(MD_MULHU, 32'hFFFF_FFFF, 32'd2, res, z, low, tmo);
    checkOutput("mulhu", res, 32'd1);
    runMd(MD_MULH, 32'hFFFF_FFFE, 32'd3, res, z, low, tmo);
    checkOutput("mulh", res, 32'hFFFF_FFFF);
    runMd(MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, z, low, tmo);
    checkOutput("mulhsu", res, 32'hFFFF_FFFF);
    runMd(MD_DIV, 32'hFFFF_FFF9, 32'd2, res, z, low, tmo);
    checkOutput("div_neg", res, 32'hFFFF_FFFD);
    runMd(MD_REM, 32'hFFFF_FFF9, 32'd2, res, z, low, tmo);
    checkOutput("rem_neg", res, 32'hFFFF_FFFF);
    runMd(MD_DIV, 32'd5, 32'd0, res, z, low, tmo);
    checkOutput("div_by_zero", res, 32'hFFFF_FFFF);
    checkOutput("div0_busy_cycles", 32'(low), 32'd2);
    runMd(MD_REMU, 32'd5, 32'd0, res, z, low, tmo);
    checkOutput("remu_by_zero", res, 32'd5);
    runMd(MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, res, z, low, tmo);
    checkOutput("rem_ovf", res, 32'd0);
    checkOutput("rem_ovf_zero", 32'(z), 32'd1);
    checkOutput("ovf_busy_cycles", 32'(low), 32'd2);
    runMd(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, res, z, low, tmo);
    checkOutput("div_ovf", res, 32'h8000_0000);
    runMd(MD_DIVU, 32'd100, 32'd7, res, z, low, tmo);
    checkOutput("divu", res, 32'd14);
    runMd(MD_REMU, 32'd100, 32'd7, res, z, low, tmo);
    checkOutput("remu", res, 32'd2);
    checkOutput("remu_timeout", 32'(tmo), 32'd0);

    $display("[TB] stall across DONE");
    @(negedge clk);
    valid_i = 1'b1; md_en_i = 1'b1; md_op_i = MD_DIVU; rs1_i = 32'd200; rs2_i = 32'd7;
    repeat (30) begin
      @(negedge clk);
      valid_i = 1'b0; md_en_i = 1'b0;
    end
    mem_stall_i = 1'b1;
    unstable = 0;
    repeat (5) begin
      @(negedge clk);
      if (valid_o !== 1'b0 || alu_out_o !== 32'd2) unstable++;
    end
    checkOutput("stall_stable", 32'(unstable), 32'd0);
    mem_stall_i = 1'b0;
    pulses = 0;
    res = 32'd0;
    repeat (4) begin
      @(negedge clk);
      if (valid_o) begin
        pulses++;
        res = alu_out_o;
      end
    end
    checkOutput("stall_pulses", 32'(pulses), 32'd1);
    checkOutput("stall_result", res, 32'd28);

    $display("[TB] flush and reset abort");
    @(negedge clk);
    valid_i = 1'b1; md_en_i = 1'b1; md_op_i = MD_MUL; rs1_i = 32'd3; rs2_i = 32'd3;
    repeat (10) begin
      @(negedge clk);
      valid_i = 1'b0; md_en_i = 1'b0;
    end
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    checkOutput("flush_ready", 32'(ready_o), 32'd1);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid_o) pulses++;
    end
    checkOutput("flush_no_result", 32'(pulses), 32'd0);

    valid_i = 1'b1; md_en_i = 1'b1; md_op_i = MD_DIV; rs1_i = 32'd50; rs2_i = 32'd5;
    repeat (6) begin
      @(negedge clk);
      valid_i = 1'b0; md_en_i = 1'b0;
    end
    checkOutput("busy_before_reset", 32'(ready_o), 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_ready", 32'(ready_o), 32'd1);
    checkOutput("reset_alu", alu_out_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid_o) pulses++;
    end
    checkOutput("reset_no_result", 32'(pulses), 32'd0);
    checkOutput("reset_ready_end", 32'(ready_o), 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
